// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, assembles one- or
// two-word instructions and presents them as a registered bundle.
module fetch_unit #(
  parameter int              PC_W         = 32,
  parameter int              INSTR_W      = 16,
  parameter logic [PC_W-1:0] RESET_VECTOR = 'h20,
  parameter logic [PC_W-1:0] INT_VECTOR   = '0,
  parameter int              IMM_FLAG_BIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               jumpBit,
  input  logic [PC_W-1:0]    branchTarget,
  input  logic               interruptBit,
  output logic [PC_W-1:0]    imemAddr,
  input  logic [INSTR_W-1:0] imemData,
  output logic               outValid,
  output logic [INSTR_W-1:0] outInstr,
  output logic [INSTR_W-1:0] outImm,
  output logic [PC_W-1:0]    outPc,
  output logic [PC_W-1:0]    outNextPc,
  output logic [PC_W-1:0]    intRetPc
);

  // Handshake: outValid is asserted for every cycle the bundle holds a
  // complete instruction; there is no ready, the consumer freezes the
  // stage with stall. A new bundle appears on each unstalled edge that
  // completes an instruction.

  typedef enum logic {S_INSTR = 1'b0, S_IMM = 1'b1} state_t;

  state_t            state, state_next;
  logic [PC_W-1:0]   pc, pc_inc;
  logic [INSTR_W-1:0] buf_instr;
  logic [PC_W-1:0]   buf_pc;
  logic              advance, start_imm, emit;

  assign imemAddr = pc;
  assign pc_inc   = pc + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_INSTR;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (interruptBit || jumpBit) begin
      state_next = S_INSTR;
    end else if (!stall) begin
      case (state)
        S_INSTR: if (imemData[IMM_FLAG_BIT]) state_next = S_IMM;
        S_IMM:   state_next = S_INSTR;
        default: state_next = S_INSTR;
      endcase
    end
  end

  // Per-edge actions decoded from state and request priority
  always_comb begin
    advance   = !interruptBit && !jumpBit && !stall;
    start_imm = advance && (state == S_INSTR) && imemData[IMM_FLAG_BIT];
    emit      = advance && !start_imm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_VECTOR;
      outValid  <= 1'b0;
      outInstr  <= '0;
      outImm    <= '0;
      outPc     <= '0;
      outNextPc <= '0;
      intRetPc  <= '0;
      buf_instr <= '0;
      buf_pc    <= '0;
    end else if (interruptBit) begin
      // A half-assembled instruction is refetched from its first word.
      intRetPc <= (state == S_IMM) ? buf_pc : pc;
      pc       <= INT_VECTOR;
      outValid <= 1'b0;
    end else if (jumpBit) begin
      pc       <= branchTarget;
      outValid <= 1'b0;
    end else if (advance) begin
      pc <= pc_inc;
      if (start_imm) begin
        buf_instr <= imemData;
        buf_pc    <= pc;
        outValid  <= 1'b0;
      end else if (emit) begin
        outInstr  <= (state == S_IMM) ? buf_instr : imemData;
        outImm    <= (state == S_IMM) ? imemData : '0;
        outPc     <= (state == S_IMM) ? buf_pc : pc;
        outNextPc <= pc_inc;
        outValid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: instruction-level reference model,
// expected-bundle queue and an independent output monitor.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, PC_W = 32
  logic        rst = 1'b1, stall = 1'b0, jumpBit = 1'b0, interruptBit = 1'b0;
  logic [31:0] branchTarget = '0;
  logic [31:0] imemAddr, outPc, outNextPc, intRetPc;
  logic [15:0] imemData, outInstr, outImm;
  logic        outValid;

  // Narrow instance, PC_W = 8, for wrap-around
  logic        w_rst = 1'b1, w_jump = 1'b0, w_int = 1'b0;
  logic [7:0]  w_target = '0;
  logic [7:0]  w_addr, w_pc, w_next, w_intret;
  logic [15:0] w_data, w_instr, w_imm;
  logic        w_valid;

  logic [15:0] mem [256];
  assign imemData = mem[imemAddr[7:0]];
  assign w_data   = mem[w_addr];

  fetch_unit #(.PC_W(32), .INSTR_W(16), .RESET_VECTOR(32'h20),
               .INT_VECTOR(32'h0), .IMM_FLAG_BIT(15)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jumpBit(jumpBit),
    .branchTarget(branchTarget), .interruptBit(interruptBit),
    .imemAddr(imemAddr), .imemData(imemData), .outValid(outValid),
    .outInstr(outInstr), .outImm(outImm), .outPc(outPc),
    .outNextPc(outNextPc), .intRetPc(intRetPc)
  );

  fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_VECTOR(8'h20),
               .INT_VECTOR(8'h0), .IMM_FLAG_BIT(15)) dut_w (
    .clk(clk), .rst(w_rst), .stall(1'b0), .jumpBit(w_jump),
    .branchTarget(w_target), .interruptBit(w_int),
    .imemAddr(w_addr), .imemData(w_data), .outValid(w_valid),
    .outInstr(w_instr), .outImm(w_imm), .outPc(w_pc),
    .outNextPc(w_next), .intRetPc(w_intret)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Words consumed since the last redirect form the instruction under
  // assembly; an instruction is complete after one word, or two when the
  // first word carries the immediate flag.
  logic [31:0] mpc        = 32'h20;
  logic        exp_valid  = 1'b0;
  logic [31:0] exp_intret = '0;
  logic [31:0] pa [$];
  logic [15:0] pw [$];
  logic [95:0] exp_q [$];

  task automatic step(input logic st, input logic jb, input logic [31:0] tgt,
                      input logic ib, input logic r);
    logic [15:0] w;
    @(negedge clk);
    rst = r; stall = st; jumpBit = jb; branchTarget = tgt; interruptBit = ib;
    if (r) begin
      mpc = 32'h20; exp_valid = 1'b0; exp_intret = '0;
      pa.delete(); pw.delete();
    end else if (ib) begin
      exp_intret = (pa.size() != 0) ? pa[0] : mpc;
      mpc = 32'h0; exp_valid = 1'b0;
      pa.delete(); pw.delete();
    end else if (jb) begin
      mpc = tgt; exp_valid = 1'b0;
      pa.delete(); pw.delete();
    end else if (!st) begin
      w = mem[mpc[7:0]];
      pa.push_back(mpc); pw.push_back(w);
      mpc = mpc + 32'd1;
      if (!pw[0][15] || pw.size() == 2) begin
        exp_q.push_back({pw[0], (pw.size() == 2) ? pw[1] : 16'h0, pa[0], mpc});
        exp_valid = 1'b1;
        pa.delete(); pw.delete();
      end else begin
        exp_valid = 1'b0;
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [95:0] prev_b, cur_b, exp_b;
    logic s_r, s_s, s_j, s_i;
    prev_b = '0;
    forever begin
      @(posedge clk);
      s_r = rst; s_s = stall; s_j = jumpBit; s_i = interruptBit;
      #1;
      cur_b = {outInstr, outImm, outPc, outNextPc};
      check("imemAddr", {64'h0, imemAddr}, {64'h0, mpc});
      check("outValid", {95'h0, outValid}, {95'h0, exp_valid});
      check("intRetPc", {64'h0, intRetPc}, {64'h0, exp_intret});
      if (s_r) begin
        check("reset_bundle", cur_b, 96'h0);
      end else if (!s_i && !s_j && s_s) begin
        check("stall_hold", cur_b, prev_b);
      end else if (!s_i && !s_j && outValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bundle", cur_b, 96'hx);
        end else begin
          exp_b = exp_q.pop_front();
          check("bundle", cur_b, exp_b);
        end
      end
      prev_b = cur_b;
    end
  end

  // ---------------- stimulus ----------------
  task automatic w_check(input string name, input logic [7:0] act, input logic [7:0] req);
    check(name, {88'h0, act}, {88'h0, req});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom());
    mem[8'h20] = 16'h0123; mem[8'h21] = 16'h8005; mem[8'h22] = 16'h00FF;
    mem[8'h23] = 16'h8011; mem[8'h24] = 16'h0022; mem[8'h25] = 16'h8000;
    mem[8'h26] = 16'h7777; mem[8'h00] = 16'h0001; mem[8'h40] = 16'h8ABC;
    mem[8'h41] = 16'h1234; mem[8'h50] = 16'h0002; mem[8'hFF] = 16'h0042;
    mem[8'h30] = 16'h0003;

    // Narrow instance: wrap-around and reset-over-interrupt
    @(negedge clk); w_rst = 1'b1;
    @(posedge clk); #2;
    w_check("w_reset_addr", w_addr, 8'h20);
    w_check("w_reset_intret", w_intret, 8'h00);
    @(negedge clk); w_rst = 1'b0; w_jump = 1'b1; w_target = 8'hFF;
    @(posedge clk); #2;
    w_check("w_jump_addr", w_addr, 8'hFF);
    w_check("w_jump_valid", {7'h0, w_valid}, 8'h00);
    @(negedge clk); w_jump = 1'b0;
    @(posedge clk); #2;
    w_check("w_wrap_valid", {7'h0, w_valid}, 8'h01);
    w_check("w_wrap_pc", w_pc, 8'hFF);
    w_check("w_wrap_next", w_next, 8'h00);
    w_check("w_wrap_addr", w_addr, 8'h00);
    @(negedge clk); w_jump = 1'b1; w_target = 8'h30;
    @(negedge clk); w_jump = 1'b0; w_int = 1'b1;
    @(posedge clk); #2;
    w_check("w_int_intret", w_intret, 8'h30);
    @(negedge clk); w_rst = 1'b1; w_int = 1'b1;
    @(posedge clk); #2;
    w_check("w_rst_int_intret", w_intret, 8'h00);
    w_check("w_rst_int_addr", w_addr, 8'h20);
    w_check("w_rst_int_valid", {7'h0, w_valid}, 8'h00);
    @(negedge clk); w_rst = 1'b0; w_int = 1'b0;

    // Main instance: directed walk through the documented scenarios
    step(0, 0, 0, 0, 1);            // reset
    step(0, 0, 0, 0, 0);            // 0x20 one-word
    step(0, 0, 0, 0, 0);            // 0x21 instruction word
    step(0, 0, 0, 0, 0);            // 0x22 immediate
    step(0, 0, 0, 0, 0);            // 0x23 instruction word
    repeat (3) step(1, 0, 0, 0, 0); // stall mid two-word
    step(0, 0, 0, 0, 0);            // 0x24 immediate
    step(0, 0, 0, 0, 0);            // 0x25 instruction word
    step(1, 1, 32'h100, 0, 0);      // branch beats stall, buffer dropped
    step(0, 0, 0, 0, 0);            // 0x100 one-word
    step(0, 1, 32'h40, 0, 0);
    step(0, 0, 0, 0, 0);            // 0x40 instruction word
    step(0, 1, 32'h77, 1, 0);       // interrupt in S_IMM beats branch
    step(0, 0, 0, 0, 0);            // vector 0 one-word
    step(0, 1, 32'h50, 0, 0);
    step(0, 0, 0, 1, 0);            // interrupt in S_INSTR at 0x50
    step(0, 0, 0, 0, 0);

    // Randomized phase
    for (int n = 0; n < 600; n++) begin
      logic st, jb, ib, r;
      logic [31:0] tgt;
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 255)] = 16'($urandom());
      st  = ($urandom_range(0, 99) < 20);
      jb  = ($urandom_range(0, 99) < 6);
      ib  = ($urandom_range(0, 99) < 3);
      r   = ($urandom_range(0, 199) == 0);
      tgt = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom();
      step(st, jb, tgt, ib, r);
    end
    step(0, 0, 0, 0, 0);
    @(posedge clk); #3;
    check("queue_drained", 96'(exp_q.size()), 96'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor fetch stage: owns the program counter and drives an external instruction memory read port.
- Assembles one- or two-word instructions (instruction word plus trailing immediate word) with a 2-state FSM.
- Delivers them through a registered fetch/decode pipeline output with valid flag.
- Redirects on reset, interrupt and branch with a fixed priority, flushes partially assembled instructions, and records the interrupt return PC.

Parameters:
PC_W, 32, program counter and address width
INSTR_W, 16, instruction/immediate word width
RESET_VECTOR, 32'h20, PC loaded on reset
INT_VECTOR, 0, PC loaded on interrupt
IMM_FLAG_BIT, 15, instruction bit that marks a two-word (immediate) instruction

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold all state when high (unless redirect)
jumpBit  in  1  branch redirect request
branchTarget  in  PC_W  branch target address
interruptBit  in  1  interrupt redirect request
imemAddr  out  PC_W  instruction memory read address (= pc, combinational)
imemData  in  INSTR_W  instruction memory read data, combinational read of imemAddr
outValid  out  1  output bundle holds a complete instruction
outInstr  out  INSTR_W  instruction word
outImm  out  INSTR_W  immediate word (0 for one-word instructions)
outPc  out  PC_W  address of outInstr
outNextPc  out  PC_W  address following the whole instruction
intRetPc  out  PC_W  return address captured on interrupt

Behaviour:
- Priority per edge: rst > interruptBit > jumpBit > stall > normal fetch.
- rst: pc<=RESET_VECTOR, state<=S_INSTR, outValid<=0, outInstr/outImm/outPc/outNextPc/intRetPc<=0, buffers<=0.
- interruptBit: intRetPc<=(state==S_IMM ? bufPc : pc); pc<=INT_VECTOR; state<=S_INSTR; outValid<=0. Overrides stall and jumpBit.
- jumpBit: pc<=branchTarget; state<=S_INSTR; outValid<=0; partial instruction discarded. Overrides stall.
- stall (no redirect): every register holds, including outValid and outputs.
- S_INSTR, normal fetch:
  - imemData[IMM_FLAG_BIT]==1: bufInstr<=imemData, bufPc<=pc, pc<=pc+1, outValid<=0, state<=S_IMM.
  - else: outInstr<=imemData, outImm<=0, outPc<=pc, outNextPc<=pc+1, outValid<=1, pc<=pc+1.
- S_IMM, normal fetch: outInstr<=bufInstr, outImm<=imemData, outPc<=bufPc, outNextPc<=pc+1, outValid<=1, pc<=pc+1, state<=S_INSTR.
- Latency: one-word instruction visible 1 cycle after its fetch; two-word instruction visible 1 cycle after its immediate fetch.
- Throughput: 1 word per unstalled cycle.
- Arithmetic: pc+1 modulo 2^PC_W (all-ones wraps to 0), no flag.
- imemAddr always equals current pc register.
- intRetPc changes only on interrupt or reset.
- Redirect during S_IMM: immediate not consumed, instruction lost (refetched via intRetPc on interrupt).

Test Plan:
- Reset: rst=1 one cycle -> imemAddr=0x20, outValid=0, all outputs 0. After release, memory[0x20]=0x0123 -> next cycle outValid=1, outInstr=0x0123, outPc=0x20, outNextPc=0x21.
- Two-word: memory[0x21]=0x8005, memory[0x22]=0x00FF -> cycle 1 outValid=0; cycle 2 outInstr=0x8005, outImm=0x00FF, outPc=0x21, outNextPc=0x23.
- Stall: stall=1 for 3 cycles mid two-word fetch -> pc, state and outputs frozen. Release -> same bundle as unstalled case, one cycle per word.
- Branch vs stall: jumpBit=1, branchTarget=0x100, stall=1 -> imemAddr=0x100, outValid=0 next cycle. Prior S_IMM buffer discarded.
- Interrupt in S_IMM at bufPc=0x40 with jumpBit=1 -> intRetPc=0x40, imemAddr=INT_VECTOR=0, outValid=0. Interrupt in S_INSTR at pc=0x50 -> intRetPc=0x50.
- Wrap: PC_W=8, pc=0xFF one-word fetch -> outNextPc=0x00, imemAddr=0x00. rst asserted together with interruptBit -> reset values, intRetPc=0.
